// File: rtl/rom_fetch_pkg.sv
// Shared types and default sizing for the ROM fetch stage.
// The ROM_FETCH_WRAP_EN macro (used by rom_fetch_unit) selects wrap versus halt at the end of the ROM.
package rom_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  localparam int         ADDR_W_DEF      = 3;
  localparam int         DATA_W_DEF      = 8;
  localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;

  // True when addr is the last ROM location for the given width.
  function automatic logic is_last_addr(input logic [31:0] addr, input int addr_w);
    return addr == ((32'd1 << addr_w) - 32'd1);
  endfunction

endpackage

// File: rtl/rom_fetch_pc.sv
// Program counter for the fetch stage: clear, redirect and increment with a last-address flag.
module rom_fetch_pc
  import rom_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              last
);

  // Priority: reset, restart-clear, redirect, then increment (wraps naturally).
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_addr;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

  assign last = is_last_addr(32'(pc), ADDR_W);

endmodule

// File: rtl/rom_fetch_unit.sv
// ROM fetch stage: drives the ROM address from the PC and hands words to decode over valid/ready.
// Define ROM_FETCH_WRAP_EN to keep fetching past the last ROM word instead of halting there.
module rom_fetch_unit
  import rom_fetch_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter logic [DATA_W-1:0] HALT_OPCODE = DATA_W'(HALT_OPCODE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] ROM_address,
  input  logic [DATA_W-1:0] ROM_data,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              pc_last;
  logic              load_go;
  logic              pc_clear;
  logic              pc_jump;
  logic              end_hit;
  logic              halt_hit;

  // A jump takes priority over a load; a load needs an empty or draining output register.
  assign load_go  = (state == FETCH) && !jump_en && (!instr_valid || instr_ready);
  assign pc_clear = start && ((state == IDLE) || (state == HALT));
  assign pc_jump  = (state == FETCH) && jump_en;

`ifdef ROM_FETCH_WRAP_EN
  assign end_hit = 1'b0;
`else
  assign end_hit = pc_last;
`endif

  assign halt_hit = load_go && ((ROM_data == HALT_OPCODE) || end_hit);

  rom_fetch_pc #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .clear     (pc_clear),
    .load      (pc_jump),
    .load_addr (jump_addr),
    .inc       (load_go),
    .pc        (pc),
    .last      (pc_last)
  );

  assign ROM_address = pc;
  assign halted      = (state == HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state <= FETCH;
        end
        FETCH: begin
          if (jump_en) begin
            instr_valid <= 1'b0;
          end else if (load_go) begin
            instr_out   <= ROM_data;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            if (halt_hit) state <= HALT;
          end
        end
        HALT: begin
          // The last captured word is still owed to decode before valid drops.
          if (instr_valid && instr_ready) instr_valid <= 1'b0;
          if (start) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
